// File: rtl/scarv_cop_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// scarv_cop_dispatch_pkg : shared class/status codes and FSM state type
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package scarv_cop_dispatch_pkg;

  localparam int NFU = 7;

  // Class codes double as FU indices; class 7 has no FU.
  localparam logic [2:0] SCARV_COP_ICLASS_MOVE         = 3'd0;
  localparam logic [2:0] SCARV_COP_ICLASS_RANDOM       = 3'd1;
  localparam logic [2:0] SCARV_COP_ICLASS_MP           = 3'd2;
  localparam logic [2:0] SCARV_COP_ICLASS_BITWISE      = 3'd3;
  localparam logic [2:0] SCARV_COP_ICLASS_PACKED_ARITH = 3'd4;
  localparam logic [2:0] SCARV_COP_ICLASS_TWIDDLE      = 3'd5;
  localparam logic [2:0] SCARV_COP_ICLASS_LOADSTORE    = 3'd6;
  localparam logic [2:0] SCARV_COP_ICLASS_ILLEGAL      = 3'd7;

  localparam logic [2:0] SCARV_COP_INSN_SUCCESS = 3'd0;
  localparam logic [2:0] SCARV_COP_INSN_ABORT   = 3'd1;
  localparam logic [2:0] SCARV_COP_INSN_BAD_INS = 3'd2;
  localparam logic [2:0] SCARV_COP_INSN_BAD_LAD = 3'd3;
  localparam logic [2:0] SCARV_COP_INSN_BAD_SAD = 3'd4;
  localparam logic [2:0] SCARV_COP_INSN_TIMEOUT = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/scarv_cop_dispatch_sel.sv
// ---------------------------------------------------------------------------
// scarv_cop_dispatch_sel : class to one-hot FU decode and one-hot result mux
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module scarv_cop_dispatch_sel
  import scarv_cop_dispatch_pkg::*;
(
  input  logic [2:0]   id_class_i,
  input  logic         id_exception_i,
  output logic [6:0]   onehot_o,
  output logic         legal_o,
  input  logic [6:0]   sel_i,
  input  logic [223:0] fu_rdata_i,
  input  logic [20:0]  fu_status_i,
  output logic [31:0]  rdata_o,
  output logic [2:0]   status_o
);

  always_comb begin
    onehot_o = '0;
    legal_o  = !id_exception_i && (id_class_i != SCARV_COP_ICLASS_ILLEGAL);
    for (int k = 0; k < NFU; k++) begin
      onehot_o[k] = (id_class_i == 3'(k));
    end
  end

  // sel_i is one-hot, so OR-ing the gated slices is a plain mux.
  always_comb begin
    rdata_o  = '0;
    status_o = '0;
    for (int k = 0; k < NFU; k++) begin
      if (sel_i[k]) begin
        rdata_o  = rdata_o  | fu_rdata_i[32*k +: 32];
        status_o = status_o | fu_status_i[3*k +: 3];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/scarv_cop_dispatch.sv
// ---------------------------------------------------------------------------
// scarv_cop_dispatch : issues one decoded COP instruction to its FU and holds
// the response until the CPU accepts it.   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module scarv_cop_dispatch
  import scarv_cop_dispatch_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic         g_clk,
  input  logic         g_reset,
  input  logic         insn_valid,
  output logic         insn_ready,
  input  logic         id_exception,
  input  logic [2:0]   id_class,
  input  logic [3:0]   id_subclass,
  input  logic [4:0]   id_rd,
  output logic [6:0]   fu_ivalid,
  output logic [3:0]   fu_subclass,
  input  logic [6:0]   fu_idone,
  input  logic [223:0] fu_rdata,
  input  logic [20:0]  fu_status,
  output logic         cpu_rsp_valid,
  input  logic         cpu_rsp_ready,
  output logic [2:0]   cpu_rsp_status,
  output logic [4:0]   cpu_rsp_rd,
  output logic [31:0]  cpu_rsp_data
);

  localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

  state_e        state_q,  state_d;
  logic [6:0]    sel_q,    sel_d;
  logic [3:0]    sub_q,    sub_d;
  logic [4:0]    rd_q,     rd_d;
  logic [2:0]    status_q, status_d;
  logic [31:0]   data_q,   data_d;
  logic [TW-1:0] cnt_q,    cnt_d;

  logic [6:0]  w_dec_onehot;
  logic        w_dec_legal;
  logic [31:0] w_mux_rdata;
  logic [2:0]  w_mux_status;
  logic        w_done_sel;
  logic        w_timeout_hit;

  scarv_cop_dispatch_sel u_sel (
    .id_class_i     (id_class),
    .id_exception_i (id_exception),
    .onehot_o       (w_dec_onehot),
    .legal_o        (w_dec_legal),
    .sel_i          (sel_q),
    .fu_rdata_i     (fu_rdata),
    .fu_status_i    (fu_status),
    .rdata_o        (w_mux_rdata),
    .status_o       (w_mux_status)
  );

  assign w_done_sel    = |(fu_idone & sel_q);
  assign w_timeout_hit = (TIMEOUT != 0) && (cnt_q == TIMEOUT_CNT);

  assign insn_ready     = (state_q == ST_IDLE);
  assign fu_ivalid      = (state_q == ST_ISSUE) ? sel_q : 7'd0;
  assign fu_subclass    = sub_q;
  assign cpu_rsp_valid  = (state_q == ST_RESP);
  assign cpu_rsp_status = status_q;
  assign cpu_rsp_rd     = rd_q;
  assign cpu_rsp_data   = data_q;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    sub_d    = sub_q;
    rd_d     = rd_q;
    status_d = status_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (insn_valid) begin
          sel_d = w_dec_onehot;
          sub_d = id_subclass;
          rd_d  = id_rd;
          if (!w_dec_legal) begin
            status_d = SCARV_COP_INSN_BAD_INS;
            data_d   = '0;
            state_d  = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // Saturating count; only meaningful when the timeout is disabled.
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (w_done_sel) begin
          status_d = w_mux_status;
          data_d   = w_mux_rdata;
          state_d  = ST_RESP;
        end else if (w_timeout_hit) begin
          status_d = SCARV_COP_INSN_TIMEOUT;
          data_d   = '0;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (cpu_rsp_ready) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      sub_q    <= '0;
      rd_q     <= '0;
      status_q <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      sub_q    <= sub_d;
      rd_q     <= rd_d;
      status_q <= status_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_scarv_cop_dispatch.sv
// ---------------------------------------------------------------------------
// tb_scarv_cop_dispatch : two instances (TIMEOUT 64 and 4) checked against a
// transaction-level model, plus directed scenarios.   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_scarv_cop_dispatch;

  logic         g_clk = 1'b0;
  logic         g_reset = 1'b1;
  logic         insn_valid = 1'b0;
  logic         id_exception = 1'b0;
  logic [2:0]   id_class = '0;
  logic [3:0]   id_subclass = '0;
  logic [4:0]   id_rd = '0;
  logic [6:0]   fu_idone = '0;
  logic [223:0] fu_rdata = '0;
  logic [20:0]  fu_status = '0;
  logic         cpu_rsp_ready = 1'b0;

  logic [1:0]       rdy_w;
  logic [1:0][6:0]  iv_w;
  logic [1:0][3:0]  sub_w;
  logic [1:0]       rv_w;
  logic [1:0][2:0]  st_w;
  logic [1:0][4:0]  rd_w;
  logic [1:0][31:0] dat_w;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 g_clk = ~g_clk;

  scarv_cop_dispatch #(.TIMEOUT(64), .TW(7)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .insn_valid(insn_valid), .insn_ready(rdy_w[0]),
    .id_exception(id_exception), .id_class(id_class), .id_subclass(id_subclass), .id_rd(id_rd),
    .fu_ivalid(iv_w[0]), .fu_subclass(sub_w[0]), .fu_idone(fu_idone), .fu_rdata(fu_rdata),
    .fu_status(fu_status), .cpu_rsp_valid(rv_w[0]), .cpu_rsp_ready(cpu_rsp_ready),
    .cpu_rsp_status(st_w[0]), .cpu_rsp_rd(rd_w[0]), .cpu_rsp_data(dat_w[0]));

  scarv_cop_dispatch #(.TIMEOUT(4), .TW(3)) dut_t (
    .g_clk(g_clk), .g_reset(g_reset), .insn_valid(insn_valid), .insn_ready(rdy_w[1]),
    .id_exception(id_exception), .id_class(id_class), .id_subclass(id_subclass), .id_rd(id_rd),
    .fu_ivalid(iv_w[1]), .fu_subclass(sub_w[1]), .fu_idone(fu_idone), .fu_rdata(fu_rdata),
    .fu_status(fu_status), .cpu_rsp_valid(rv_w[1]), .cpu_rsp_ready(cpu_rsp_ready),
    .cpu_rsp_status(st_w[1]), .cpu_rsp_rd(rd_w[1]), .cpu_rsp_data(dat_w[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int to_of(input int m);
    return (m == 0) ? 64 : 4;
  endfunction

  // Model: mode 0 = waiting for an instruction, 1 = FU busy, 2 = response held.
  int          m_mode [2];
  int          m_sel  [2];
  int          m_age  [2];
  logic [3:0]  m_sub  [2];
  logic [4:0]  m_rd   [2];
  logic [2:0]  m_st   [2];
  logic [31:0] m_data [2];

  always @(posedge g_clk) begin
    for (int m = 0; m < 2; m++) begin
      if (g_reset) begin
        m_mode[m] <= 0; m_sel[m] <= 0; m_age[m] <= 0;
        m_sub[m] <= '0; m_rd[m] <= '0; m_st[m] <= '0; m_data[m] <= '0;
      end else if (m_mode[m] == 0) begin
        if (insn_valid) begin
          m_sub[m] <= id_subclass;
          m_rd[m]  <= id_rd;
          if (id_exception || id_class == 3'd7) begin
            m_mode[m] <= 2; m_st[m] <= 3'd2; m_data[m] <= '0;
          end else begin
            m_mode[m] <= 1; m_sel[m] <= int'(id_class); m_age[m] <= 0;
          end
        end
      end else if (m_mode[m] == 1) begin
        if (fu_idone[m_sel[m]]) begin
          m_st[m]   <= fu_status[3*m_sel[m] +: 3];
          m_data[m] <= fu_rdata[32*m_sel[m] +: 32];
          m_mode[m] <= 2;
        end else if (m_age[m] == to_of(m)) begin
          m_st[m] <= 3'd5; m_data[m] <= '0; m_mode[m] <= 2;
        end else begin
          m_age[m] <= m_age[m] + 1;
        end
      end else if (cpu_rsp_ready) begin
        m_mode[m] <= 0;
      end
    end
  end

  always @(negedge g_clk) begin
    if (cmp_en) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("ready%0d", m), 32'(rdy_w[m]), 32'(m_mode[m] == 0));
        chk($sformatf("ivalid%0d", m), 32'(iv_w[m]), (m_mode[m] == 1) ? (32'd1 << m_sel[m]) : 32'd0);
        chk($sformatf("subcls%0d", m), 32'(sub_w[m]), 32'(m_sub[m]));
        chk($sformatf("rspvalid%0d", m), 32'(rv_w[m]), 32'(m_mode[m] == 2));
        chk($sformatf("status%0d", m), 32'(st_w[m]), 32'(m_st[m]));
        chk($sformatf("rd%0d", m), 32'(rd_w[m]), 32'(m_rd[m]));
        chk($sformatf("data%0d", m), dat_w[m], m_data[m]);
      end
    end
  end

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic accept(input logic [2:0] cls, input logic [3:0] sub, input logic [4:0] rd,
                        input logic exc);
    insn_valid = 1'b1; id_class = cls; id_subclass = sub; id_rd = rd; id_exception = exc;
    step();
    insn_valid = 1'b0; id_exception = 1'b0;
  endtask

  task automatic handshake();
    cpu_rsp_ready = 1'b1;
    step();
    cpu_rsp_ready = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk({tag, "_ready"}, 32'(rdy_w[m]), 32'd1);
      chk({tag, "_ivalid"}, 32'(iv_w[m]), 32'd0);
      chk({tag, "_rspvalid"}, 32'(rv_w[m]), 32'd0);
      chk({tag, "_data"}, dat_w[m], 32'd0);
      chk({tag, "_rd"}, 32'(rd_w[m]), 32'd0);
    end
  endtask

  int cnt;

  initial begin
    step(); step();
    cmp_en = 1'b1;
    @(negedge g_clk);
    chk_reset_state("reset");
    step();
    g_reset = 1'b0;

    // Legal BITWISE with a one-cycle FU.
    accept(3'd3, 4'h5, 5'd9, 1'b0);
    fu_idone = 7'b0001000; fu_rdata[3*32 +: 32] = 32'hDEADBEEF; fu_status[3*3 +: 3] = 3'd0;
    @(negedge g_clk);
    chk("bw_ivalid", 32'(iv_w[0]), 32'h08);
    chk("bw_subcls", 32'(sub_w[0]), 32'h5);
    step();
    fu_idone = '0;
    @(negedge g_clk);
    chk("bw_rspvalid", 32'(rv_w[0]), 32'd1);
    chk("bw_ivalid_drop", 32'(iv_w[0]), 32'd0);
    chk("bw_rd", 32'(rd_w[0]), 32'd9);
    chk("bw_data", dat_w[0], 32'hDEADBEEF);
    handshake();

    // Decoder exception, then class 7.
    accept(3'd3, 4'h1, 5'd4, 1'b1);
    @(negedge g_clk);
    chk("exc_status", 32'(st_w[0]), 32'd2);
    chk("exc_data", dat_w[0], 32'd0);
    chk("exc_ivalid", 32'(iv_w[0]), 32'd0);
    handshake();
    accept(3'd7, 4'h2, 5'd17, 1'b0);
    @(negedge g_clk);
    chk("cls7_status", 32'(st_w[1]), 32'd2);
    chk("cls7_rd", 32'(rd_w[1]), 32'd17);
    handshake();

    // MP, FU done on the tenth ISSUE cycle, CPU stalls 5 cycles.
    accept(3'd2, 4'h3, 5'd12, 1'b0);
    fu_rdata[2*32 +: 32] = 32'h12345678; fu_status[2*3 +: 3] = 3'd3;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      fu_idone = (i == 9) ? 7'b0000100 : 7'd0;
      @(negedge g_clk);
      if (iv_w[0][2]) cnt++;
      step();
    end
    fu_idone = '0;
    chk("mp_ivalid_cycles", 32'(cnt), 32'd10);
    cnt = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge g_clk);
      if (rv_w[0] && dat_w[0] == 32'h12345678 && st_w[0] == 3'd3) cnt++;
      step();
    end
    chk("mp_rsp_stable", 32'(cnt), 32'd5);
    handshake();
    @(negedge g_clk);
    chk("mp_ready_back", 32'(rdy_w[0]), 32'd1);

    // RANDOM op whose FU never answers: the TIMEOUT=4 instance times out.
    accept(3'd1, 4'h0, 5'd3, 1'b0);
    repeat (7) step();
    @(negedge g_clk);
    chk("to_rspvalid", 32'(rv_w[1]), 32'd1);
    chk("to_status", 32'(st_w[1]), 32'd5);
    chk("to_data", dat_w[1], 32'd0);
    handshake();
    fu_idone = 7'b0000010;
    step();
    fu_idone = '0;
    @(negedge g_clk);
    chk("to_spurious_rv", 32'(rv_w[1]), 32'd0);
    chk("to_spurious_rdy", 32'(rdy_w[1]), 32'd1);
    handshake();

    // FU completes in the same cycle the count reaches TIMEOUT.
    accept(3'd4, 4'h7, 5'd21, 1'b0);
    fu_rdata[4*32 +: 32] = 32'hCAFEF00D; fu_status[4*3 +: 3] = 3'd1;
    for (int i = 0; i < 5; i++) begin
      fu_idone = (i == 4) ? 7'b0010000 : 7'd0;
      step();
    end
    fu_idone = '0;
    @(negedge g_clk);
    chk("race_status", 32'(st_w[1]), 32'd1);
    chk("race_data", dat_w[1], 32'hCAFEF00D);
    handshake();

    // LOADSTORE ignoring an unselected done, then reset mid-ISSUE.
    accept(3'd6, 4'h9, 5'd30, 1'b0);
    fu_idone = 7'b0000001;
    step(); step();
    fu_idone = '0;
    @(negedge g_clk);
    chk("ls_ivalid", 32'(iv_w[0]), 32'h40);
    chk("ls_rspvalid", 32'(rv_w[0]), 32'd0);
    g_reset = 1'b1;
    step();
    g_reset = 1'b0;
    @(negedge g_clk);
    chk_reset_state("midrst");
    fu_idone = 7'b1000000;
    step();
    fu_idone = '0;
    @(negedge g_clk);
    chk("midrst_norsp", 32'(rv_w[0]), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      g_reset       = ($urandom_range(0, 299) == 0);
      insn_valid    = ($urandom_range(0, 1) == 1);
      id_exception  = ($urandom_range(0, 9) == 0);
      id_class      = 3'($urandom_range(0, 7));
      id_subclass   = 4'($urandom_range(0, 15));
      id_rd         = 5'($urandom_range(0, 31));
      cpu_rsp_ready = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < 7; k++) begin
        fu_idone[k] = ($urandom_range(0, 5) == 0);
        fu_rdata[32*k +: 32] = $urandom;
        fu_status[3*k +: 3] = 3'($urandom_range(0, 7));
      end
      step();
    end
    g_reset = 1'b0; insn_valid = 1'b0; fu_idone = '0; cpu_rsp_ready = 1'b1;
    repeat (3) step();
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
